frame_merger: RTL and testbench

Downstream consumer of the frame generator's two AXI-Stream outputs (frame-data and meta-data). Merges them into one packetised AXI-Stream: MD_BEATS meta-data beats, then one frame of frame-data beats, with TLAST on the final frame-data beat. The merged stream feeds the DMA/packet-sender stage. Also provides frame and error status counters.

---
 rtl/frame_pkg.sv | 21 ++
 rtl/frame_pattern_checker.sv | 37 +++
 rtl/frame_merger.sv | 135 +++++++++++++
 tb/tb_frame_merger.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame merger slice: merger state encoding,
// AXI response codes and frame-size conversion.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MD   = 2'd1,
    FD   = 2'd2
  } state_t;

  localparam logic [1:0]  OKAY               = 2'b00;
  localparam logic [1:0]  SLVERR             = 2'b10;
  localparam logic [1:0]  DECERR             = 2'b11;
  localparam logic [31:0] DEFAULT_FRAME_SIZE = 32'd4096;

  // Whole beats in a frame of 'size' bytes on a 'dw'-bit bus (truncating).
  function automatic logic [31:0] bytes_to_beats(input logic [31:0] size, input int dw);
    return size / 32'(dw / 8);
  endfunction

endpackage

// File: rtl/frame_pattern_checker.sv
// Tracks a replicated 16-bit incrementing pattern on frame-data beats and
// counts mismatches, resynchronising to the observed value after each error.
module frame_pattern_checker #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          beat_valid,
  input  logic [DW-1:0] beat_data,
  output logic [31:0]   err_count
);

  logic [15:0] expected_r;
  logic [31:0] err_r;
  logic        mismatch_s;

  assign mismatch_s = (beat_data != {(DW/16){expected_r}});
  assign err_count  = err_r;

  // Expected-value tracker and saturating mismatch counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expected_r <= 16'd1;
      err_r      <= 32'd0;
    end else if (beat_valid) begin
      if (mismatch_s) begin
        if (err_r != 32'hFFFF_FFFF) begin
          err_r <= err_r + 32'd1;
        end
        expected_r <= beat_data[15:0] + 16'd1;
      end else begin
        expected_r <= expected_r + 16'd1;
      end
    end
  end

endmodule

// File: rtl/frame_merger.sv
// Merges the meta-data and frame-data AXI-Streams into one packet per frame.
// Optional data-pattern checking is enabled with FRAME_MERGER_CHECK_EN.
module frame_merger #(
  parameter int DW       = 512,
  parameter int MD_BEATS = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   FRAME_SIZE,
  input  logic [DW-1:0] AXIS_FD_TDATA,
  input  logic          AXIS_FD_TVALID,
  output logic          AXIS_FD_TREADY,
  input  logic [DW-1:0] AXIS_MD_TDATA,
  input  logic          AXIS_MD_TVALID,
  output logic          AXIS_MD_TREADY,
  output logic [DW-1:0] AXIS_OUT_TDATA,
  output logic          AXIS_OUT_TVALID,
  output logic          AXIS_OUT_TLAST,
  input  logic          AXIS_OUT_TREADY,
  output logic [31:0]   FRAMES_OUT,
  output logic          SIZE_ERR,
  output logic [31:0]   CHECK_ERRS,
  output logic          BUSY
);
  import frame_pkg::*;

  state_t      state_r;
  logic [31:0] beat_cnt_r;
  logic [31:0] frame_beats_r;
  logic [31:0] frames_out_r;
  logic        size_err_r;
  logic [31:0] beats_s;
  logic        md_hs_s;
  logic        fd_hs_s;
  logic        last_s;
  logic [31:0] check_errs_s;

  assign beats_s = bytes_to_beats(FRAME_SIZE, DW);
  assign md_hs_s = (state_r == MD) && AXIS_MD_TVALID && AXIS_OUT_TREADY;
  assign fd_hs_s = (state_r == FD) && AXIS_FD_TVALID && AXIS_OUT_TREADY;
  assign last_s  = (state_r == FD) && (beat_cnt_r == frame_beats_r - 32'd1);

  // Zero-latency stream mux; the idle state drives everything low.
  always_comb begin
    AXIS_OUT_TDATA  = '0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_MD_TREADY  = 1'b0;
    AXIS_FD_TREADY  = 1'b0;
    case (state_r)
      MD: begin
        AXIS_OUT_TDATA  = AXIS_MD_TDATA;
        AXIS_OUT_TVALID = AXIS_MD_TVALID;
        AXIS_MD_TREADY  = AXIS_OUT_TREADY;
      end
      FD: begin
        AXIS_OUT_TDATA  = AXIS_FD_TDATA;
        AXIS_OUT_TVALID = AXIS_FD_TVALID;
        AXIS_OUT_TLAST  = last_s;
        AXIS_FD_TREADY  = AXIS_OUT_TREADY;
      end
      default: begin
        AXIS_OUT_TDATA  = '0;
      end
    endcase
  end

  // Packet sequencing FSM with frame and size-error status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      beat_cnt_r    <= 32'd0;
      frame_beats_r <= 32'd1;
      frames_out_r  <= 32'd0;
      size_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (AXIS_MD_TVALID) begin
            // A zero-beat frame still carries one data beat so TLAST is emitted.
            if (beats_s == 32'd0) begin
              frame_beats_r <= 32'd1;
              size_err_r    <= 1'b1;
            end else begin
              frame_beats_r <= beats_s;
            end
            beat_cnt_r <= 32'd0;
            state_r    <= MD;
          end
        end
        MD: begin
          if (md_hs_s) begin
            if (beat_cnt_r == 32'(MD_BEATS - 1)) begin
              beat_cnt_r <= 32'd0;
              state_r    <= FD;
            end else begin
              beat_cnt_r <= beat_cnt_r + 32'd1;
            end
          end
        end
        FD: begin
          if (fd_hs_s) begin
            if (last_s) begin
              frames_out_r <= frames_out_r + 32'd1;
              state_r      <= IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + 32'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_MERGER_CHECK_EN
  frame_pattern_checker #(.DW(DW)) u_checker (
    .clk        (clk),
    .resetn     (resetn),
    .beat_valid (fd_hs_s),
    .beat_data  (AXIS_FD_TDATA),
    .err_count  (check_errs_s)
  );
`else
  assign check_errs_s = 32'd0;
`endif

  assign FRAMES_OUT = frames_out_r;
  assign SIZE_ERR   = size_err_r;
  assign CHECK_ERRS = check_errs_s;
  assign BUSY       = (state_r != IDLE);

endmodule

// File: tb/tb_frame_merger.sv
// Randomised bench for frame_merger: queue-based stream sources, a random-ready
// sink, and a frame-level expected-beat model checked on every handshake.
module tb_frame_merger;

  localparam int DW       = 512;
  localparam int MD_BEATS = 2;
`ifdef FRAME_MERGER_CHECK_EN
  localparam logic [31:0] T1_ERRS = 32'd1;
`else
  localparam logic [31:0] T1_ERRS = 32'd0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          is_fd;
    logic          zero;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   FRAME_SIZE;
  logic [DW-1:0] AXIS_FD_TDATA;
  logic          AXIS_FD_TVALID;
  logic          AXIS_FD_TREADY;
  logic [DW-1:0] AXIS_MD_TDATA;
  logic          AXIS_MD_TVALID;
  logic          AXIS_MD_TREADY;
  logic [DW-1:0] AXIS_OUT_TDATA;
  logic          AXIS_OUT_TVALID;
  logic          AXIS_OUT_TLAST;
  logic          AXIS_OUT_TREADY;
  logic [31:0]   FRAMES_OUT;
  logic          SIZE_ERR;
  logic [31:0]   CHECK_ERRS;
  logic          BUSY;

  frame_merger #(.DW(DW), .MD_BEATS(MD_BEATS)) dut (
    .clk(clk), .resetn(resetn), .FRAME_SIZE(FRAME_SIZE),
    .AXIS_FD_TDATA(AXIS_FD_TDATA), .AXIS_FD_TVALID(AXIS_FD_TVALID), .AXIS_FD_TREADY(AXIS_FD_TREADY),
    .AXIS_MD_TDATA(AXIS_MD_TDATA), .AXIS_MD_TVALID(AXIS_MD_TVALID), .AXIS_MD_TREADY(AXIS_MD_TREADY),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
    .AXIS_OUT_TREADY(AXIS_OUT_TREADY), .FRAMES_OUT(FRAMES_OUT), .SIZE_ERR(SIZE_ERR),
    .CHECK_ERRS(CHECK_ERRS), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] md_q[$];
  logic [DW-1:0] fd_q[$];
  beat_t         exp_q[$];
  logic [DW-1:0] out_log[$];
  int            last_pos[$];
  int            ready_pct = 100;
  bit            md_hs = 1'b0, fd_hs = 1'b0, out_hs = 1'b0;
  int            fd_cnt = 0;
  logic [31:0]   m_frames = 32'd0;
  logic          m_size_err = 1'b0;
  logic [31:0]   m_errs = 32'd0;
`ifdef FRAME_MERGER_CHECK_EN
  logic [15:0]   m_exp16 = 16'd1;
`endif
  logic [15:0]   pat_vals [4] = '{16'd1, 16'd2, 16'd7, 16'd8};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  // Upstream sources and downstream sink: update just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (md_hs && md_q.size() > 0) void'(md_q.pop_front());
    if (fd_hs && fd_q.size() > 0) void'(fd_q.pop_front());
    AXIS_MD_TVALID  = (md_q.size() > 0);
    AXIS_MD_TDATA   = (md_q.size() > 0) ? md_q[0] : '0;
    AXIS_FD_TVALID  = (fd_q.size() > 0);
    AXIS_FD_TDATA   = (fd_q.size() > 0) ? fd_q[0] : '0;
    AXIS_OUT_TREADY = ($urandom_range(99) < ready_pct);
  end

  // Compare process: sample at the falling edge, check against the model.
  always @(negedge clk) begin
    beat_t e;
    if (!resetn) begin
      md_hs = 1'b0; fd_hs = 1'b0; out_hs = 1'b0;
      m_frames = 32'd0; m_size_err = 1'b0; m_errs = 32'd0;
`ifdef FRAME_MERGER_CHECK_EN
      m_exp16 = 16'd1;
`endif
    end else begin
      md_hs  = AXIS_MD_TVALID && AXIS_MD_TREADY;
      fd_hs  = AXIS_FD_TVALID && AXIS_FD_TREADY;
      out_hs = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
      check("frames_out", FRAMES_OUT, m_frames);
      check("check_errs", CHECK_ERRS, m_errs);
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          if (e.zero) m_size_err = 1'b1;
          check("out_data", AXIS_OUT_TDATA, e.data);
          check("out_last", AXIS_OUT_TLAST, e.last);
          check("source", e.is_fd ? (fd_hs && !md_hs) : (md_hs && !fd_hs), 1'b1);
          check("size_err", SIZE_ERR, m_size_err);
          if (AXIS_OUT_TLAST) last_pos.push_back(out_log.size());
          out_log.push_back(AXIS_OUT_TDATA);
          if (e.last) m_frames++;
        end
      end else if (md_hs || fd_hs) begin
        check("consumed_without_output", 1'b1, 1'b0);
      end
      if (fd_hs) begin
`ifdef FRAME_MERGER_CHECK_EN
        if (AXIS_FD_TDATA != {(DW/16){m_exp16}}) begin
          if (m_errs != 32'hFFFF_FFFF) m_errs++;
          m_exp16 = AXIS_FD_TDATA[15:0] + 16'd1;
        end else begin
          m_exp16 = m_exp16 + 16'd1;
        end
`endif
        fd_cnt++;
      end
    end
  end

  task automatic send_frame(input int size, input bit fd_first, input bit md_aa, input bit fd_pat);
    logic [DW-1:0] mdb[$];
    logic [DW-1:0] fdb[$];
    logic [DW-1:0] d;
    int nb;
    bit zero;
    nb   = size / (DW/8);
    zero = (nb == 0);
    if (zero) nb = 1;
    FRAME_SIZE = size;
    for (int i = 0; i < MD_BEATS; i++) begin
      d = md_aa ? {(DW/16){16'hAAAA}} : rand_beat();
      mdb.push_back(d);
      exp_q.push_back('{data: d, last: 1'b0, is_fd: 1'b0, zero: zero});
    end
    for (int i = 0; i < nb; i++) begin
      d = fd_pat ? {(DW/16){pat_vals[i % 4]}} : rand_beat();
      fdb.push_back(d);
      exp_q.push_back('{data: d, last: (i == nb - 1), is_fd: 1'b1, zero: zero});
    end
    if (fd_first) begin
      foreach (fdb[i]) fd_q.push_back(fdb[i]);
      repeat (6) begin
        @(negedge clk);
        check("fd_held_off", AXIS_FD_TREADY, 1'b0);
      end
    end
    foreach (mdb[i]) md_q.push_back(mdb[i]);
    if (!fd_first) foreach (fdb[i]) fd_q.push_back(fdb[i]);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < budget && (exp_q.size() != 0 || md_q.size() != 0 || fd_q.size() != 0 || BUSY));
    if (n >= budget) check("idle_timeout", 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    resetn = 1'b0;
    FRAME_SIZE = 32'd0;
    AXIS_MD_TVALID = 1'b0; AXIS_MD_TDATA = '0;
    AXIS_FD_TVALID = 1'b0; AXIS_FD_TDATA = '0;
    AXIS_OUT_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_out_valid", AXIS_OUT_TVALID, 1'b0);
    check("rst_frames", FRAMES_OUT, 32'd0);
    #2 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // One 256-byte frame, pattern 1,2,7,8, sink always ready.
    send_frame(256, 1'b0, 1'b0, 1'b1);
    wait_idle(200);
    check("t1_frames", FRAMES_OUT, 32'd1);
    check("t1_busy", BUSY, 1'b0);
    check("t1_beats", out_log.size(), 6);
    check("t1_tlasts", last_pos.size(), 1);
    check("t1_last_pos", (last_pos.size() > 0) ? last_pos[0] : -1, 5);
    check("t1_check_errs", CHECK_ERRS, T1_ERRS);

    // Three back-to-back 4096-byte frames under 50% backpressure.
    ready_pct = 50;
    base = out_log.size();
    for (int f = 0; f < 3; f++) send_frame(4096, 1'b0, 1'b0, 1'b0);
    wait_idle(3000);
    ready_pct = 100;
    check("t2_beats", out_log.size() - base, 3 * (MD_BEATS + 64));
    check("t2_frames", FRAMES_OUT, 32'd4);

    // Frame data presented before its header.
    base = out_log.size();
    send_frame(256, 1'b1, 1'b1, 1'b0);
    wait_idle(200);
    check("t3_first_hdr", (out_log.size() > base) ? out_log[base] : '0, {(DW/16){16'hAAAA}});
    check("t3_beats", out_log.size() - base, 6);

    // Zero-beat frame size.
    base = out_log.size();
    send_frame(32, 1'b0, 1'b0, 1'b0);
    wait_idle(200);
    check("t4_size_err", SIZE_ERR, 1'b1);
    check("t4_beats", out_log.size() - base, 3);
    check("t4_last_pos", last_pos[last_pos.size() - 1], base + 2);

    // Asynchronous reset after the second frame-data beat.
    base = fd_cnt;
    send_frame(4096, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (fd_cnt < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("t5_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("t5_out_valid", AXIS_OUT_TVALID, 1'b0);
    check("t5_out_last", AXIS_OUT_TLAST, 1'b0);
    check("t5_md_ready", AXIS_MD_TREADY, 1'b0);
    check("t5_fd_ready", AXIS_FD_TREADY, 1'b0);
    check("t5_busy", BUSY, 1'b0);
    check("t5_frames", FRAMES_OUT, 32'd0);
    check("t5_size_err", SIZE_ERR, 1'b0);
    check("t5_check_errs", CHECK_ERRS, 32'd0);
    md_q.delete();
    fd_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (2) @(posedge clk);
    base = out_log.size();
    send_frame(256, 1'b0, 1'b0, 1'b0);
    wait_idle(200);
    check("t5_post_frames", FRAMES_OUT, 32'd1);
    check("t5_post_beats", out_log.size() - base, 6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
